// File: rtl/call_register.sv
// Button front end for the elevator controller: synchronise and debounce six raw buttons,
// emit one-cycle request pulses, and keep a per-floor call-lamp register cleared by open doors.
module call_register #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic       FRQ,
   input  logic       RST,
   input  logic [2:0] interior_btn,
   input  logic [2:0] exterior_btn,
   input  logic [2:0] doors,
   output logic [2:0] interior_panel,
   output logic [2:0] exterior_panel,
   output logic [2:0] call_lamps,
   output logic       any_pending
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      ST_RELEASED = 1'b0,
      ST_PRESSED  = 1'b1
   } deb_state_t;

   // Bits 2:0 are cabin buttons, bits 5:3 are hall buttons.
   logic [5:0] w_raw;
   logic [5:0] w_stable;
   logic [5:0] w_rise;
   logic [5:0] r_stable_d;

   logic [2:0] w_int_next;
   logic [2:0] w_ext_next;
   logic [2:0] w_lamps_next;

   logic [2:0] r_int_panel;
   logic [2:0] r_ext_panel;
   logic [2:0] r_lamps;
   logic       r_any;

   assign w_raw = {exterior_btn, interior_btn};

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_btn
         logic             r_sync1;
         logic             r_sync2;
         logic [CNT_W-1:0] r_cnt;
         logic [CNT_W-1:0] w_cnt_next;
         deb_state_t       r_state;
         deb_state_t       w_state_next;

         always_ff @(posedge FRQ) begin
            if (RST) begin
               r_sync1 <= 1'b0;
               r_sync2 <= 1'b0;
               r_cnt   <= '0;
               r_state <= ST_RELEASED;
            end else begin
               r_sync1 <= w_raw[gi];
               r_sync2 <= r_sync1;
               r_cnt   <= w_cnt_next;
               r_state <= w_state_next;
            end
         end

         // The counter only runs while the synchronised input disagrees with the
         // stable value, so it never passes CNT_LAST.
         always_comb begin
            w_state_next = r_state;
            w_cnt_next   = '0;
            if (r_sync2 != w_stable[gi]) begin
               if (r_cnt == CNT_LAST) begin
                  w_state_next = r_sync2 ? ST_PRESSED : ST_RELEASED;
                  w_cnt_next   = '0;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end

         assign w_stable[gi] = (r_state == ST_PRESSED);
      end
   endgenerate

   assign w_rise = w_stable & ~r_stable_d;

   // A press at a floor whose door is already open is swallowed entirely.
   assign w_int_next   = w_rise[2:0] & ~doors;
   assign w_ext_next   = w_rise[5:3] & ~doors;
   assign w_lamps_next = (r_lamps | w_int_next | w_ext_next) & ~doors;

   always_ff @(posedge FRQ) begin
      if (RST) begin
         r_stable_d  <= '0;
         r_int_panel <= '0;
         r_ext_panel <= '0;
         r_lamps     <= '0;
         r_any       <= 1'b0;
      end else begin
         r_stable_d  <= w_stable;
         r_int_panel <= w_int_next;
         r_ext_panel <= w_ext_next;
         r_lamps     <= w_lamps_next;
         r_any       <= |w_lamps_next;
      end
   end

   assign interior_panel = r_int_panel;
   assign exterior_panel = r_ext_panel;
   assign call_lamps     = r_lamps;
   assign any_pending    = r_any;

endmodule

// File: tb/tb_call_register.sv
// Randomised bench for call_register: a window-based reference model predicts pulses,
// lamps and any_pending each cycle; directed scenarios run first, then random traffic.
module tb_call_register;

   localparam int N       = 4;
   localparam int MAXE    = 8192;
   localparam int N_RAND  = 3000;

   logic       FRQ;
   logic       RST;
   logic [2:0] interior_btn;
   logic [2:0] exterior_btn;
   logic [2:0] doors;
   logic [2:0] interior_panel;
   logic [2:0] exterior_panel;
   logic [2:0] call_lamps;
   logic       any_pending;

   int n_vec  = 0;
   int n_miss = 0;

   call_register #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut (
      .FRQ            (FRQ),
      .RST            (RST),
      .interior_btn   (interior_btn),
      .exterior_btn   (exterior_btn),
      .doors          (doors),
      .interior_panel (interior_panel),
      .exterior_panel (exterior_panel),
      .call_lamps     (call_lamps),
      .any_pending    (any_pending)
   );

   initial FRQ = 1'b0;
   always #5 FRQ = ~FRQ;

   // Reference model: a button's stable level flips at an edge when the N most recent
   // synchronised samples (raw as sampled two edges earlier) all disagree with it.
   bit         samp [6][0:MAXE-1];
   bit         m_st [6];
   bit         m_st_d [6];
   int         e        = 0;
   int         last_rst = -1;
   logic [2:0] m_int    = '0;
   logic [2:0] m_ext    = '0;
   logic [2:0] m_lamps  = '0;
   logic       m_any    = 1'b0;

   function automatic bit samp_at(input int b, input int idx);
      if (idx < 0 || idx <= last_rst) return 1'b0;
      return samp[b][idx];
   endfunction

   always @(posedge FRQ) begin
      logic [5:0] raw;
      logic [5:0] rise;
      bit         flip;
      raw = {exterior_btn, interior_btn};
      if (RST) begin
         last_rst = e;
         for (int b = 0; b < 6; b++) begin
            m_st[b]   = 1'b0;
            m_st_d[b] = 1'b0;
         end
         m_int   = '0;
         m_ext   = '0;
         m_lamps = '0;
         m_any   = 1'b0;
      end else begin
         for (int b = 0; b < 6; b++) rise[b] = m_st[b] & ~m_st_d[b];
         m_int   = rise[2:0] & ~doors;
         m_ext   = rise[5:3] & ~doors;
         m_lamps = (m_lamps | m_int | m_ext) & ~doors;
         m_any   = |m_lamps;
         for (int b = 0; b < 6; b++) begin
            flip = 1'b1;
            for (int j = e - N + 1; j <= e; j++)
               if (samp_at(b, j - 2) == m_st[b]) flip = 1'b0;
            m_st_d[b] = m_st[b];
            if (flip) m_st[b] = ~m_st[b];
         end
      end
      for (int b = 0; b < 6; b++) samp[b][e] = RST ? 1'b0 : raw[b];
      if (e < MAXE - 1) e++;
   end

   task automatic check_val(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s edge=%0d got=%b expected=%b", tag, e, got, exp);
      end
   endtask

   // Advance to the next falling edge and compare every output against the model.
   task automatic cycle();
      @(negedge FRQ);
      check_val("interior_panel", interior_panel, m_int);
      check_val("exterior_panel", exterior_panel, m_ext);
      check_val("call_lamps", call_lamps, m_lamps);
      check_val("any_pending", {2'b00, any_pending}, {2'b00, m_any});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   int         hold_left [6];
   logic [5:0] lvl;
   int         door_left;

   initial begin
      RST          = 1'b1;
      interior_btn = '0;
      exterior_btn = '0;
      doors        = '0;
      cycle();
      RST = 1'b0;
      idle(8);

      // Clean press on hall button, floor 2.
      exterior_btn[1] = 1'b1;
      idle(12);
      exterior_btn[1] = 1'b0;
      idle(10);

      // Bounce on cabin button, floor 3.
      interior_btn[2] = 1'b1; cycle();
      interior_btn[2] = 1'b0; cycle();
      interior_btn[2] = 1'b1; cycle();
      interior_btn[2] = 1'b0;
      idle(10);

      // Set floor-3 lamp, then open that door for one cycle.
      interior_btn[2] = 1'b1;
      idle(10);
      interior_btn[2] = 1'b0;
      idle(6);
      doors = 3'b100; cycle();
      doors = 3'b000;
      idle(4);
      doors = 3'b010; cycle();
      doors = 3'b000;
      idle(2);

      // Press at an open door, then the same press with the door closed.
      doors = 3'b001;
      interior_btn[0] = 1'b1;
      idle(12);
      interior_btn[0] = 1'b0;
      idle(10);
      doors = 3'b000;
      interior_btn[0] = 1'b1;
      idle(12);
      interior_btn[0] = 1'b0;
      idle(10);

      // Simultaneous presses on different floors and interior/exterior on one floor.
      interior_btn[0] = 1'b1;
      exterior_btn[2] = 1'b1;
      exterior_btn[0] = 1'b1;
      idle(12);
      interior_btn = '0;
      exterior_btn = '0;
      idle(8);
      doors = 3'b111; cycle();
      doors = 3'b000;

      // Reset in the middle of a debounce with the button still held.
      exterior_btn[2] = 1'b1;
      idle(3);
      RST = 1'b1; cycle();
      RST = 1'b0;
      idle(12);
      exterior_btn[2] = 1'b0;
      idle(10);

      // Random traffic: mixed bounce bursts and long holds, random doors, rare resets.
      lvl       = '0;
      door_left = 0;
      for (int b = 0; b < 6; b++) hold_left[b] = 0;
      for (int c = 0; c < N_RAND; c++) begin
         for (int b = 0; b < 6; b++) begin
            if (hold_left[b] == 0) begin
               lvl[b]       = 1'($urandom_range(0, 1));
               hold_left[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(4, 14));
            end
            hold_left[b]--;
         end
         interior_btn = lvl[2:0];
         exterior_btn = lvl[5:3];
         if (door_left == 0) begin
            case ($urandom_range(0, 9))
               6, 7, 8: doors = 3'(1 << $urandom_range(0, 2));
               9:       doors = 3'($urandom_range(0, 7));
               default: doors = 3'b000;
            endcase
            door_left = int'($urandom_range(1, 8));
         end
         door_left--;
         RST = ($urandom_range(0, 299) == 0);
         cycle();
      end
      RST = 1'b0;
      interior_btn = '0;
      exterior_btn = '0;
      doors = '0;
      idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
